// File: rtl/object_move_scheduler.sv
// Per-frame object move scheduler: walks the enabled object slots and fetches each direction
// word. It then issues one-pixel x steps followed by y steps over a valid/ready handshake.
module object_move_scheduler #(
    parameter int unsigned N_OBJ = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             move_clk,
    input  logic [N_OBJ-1:0] obj_en,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [5:0]       dir_in,
    output logic             step_valid,
    input  logic             step_ready,
    output logic [IDX_W-1:0] step_idx,
    output logic             step_axis,
    output logic             step_sign,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStepX,
        StStepY,
        StNext,
        StDone
    } state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_OBJ - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_OBJ-1:0] mask_q, mask_d;
    logic [1:0]       x_cnt_q, x_cnt_d;
    logic [1:0]       y_cnt_q, y_cnt_d;
    logic             sign_x_q, sign_x_d;
    logic             sign_y_q, sign_y_d;
    logic             overrun_q, overrun_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            mask_q    <= '0;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            sign_x_q  <= 1'b0;
            sign_y_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            sign_x_q  <= sign_x_d;
            sign_y_q  <= sign_y_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        sign_x_d   = sign_x_q;
        sign_y_d   = sign_y_q;
        rd_en      = 1'b0;
        rd_idx     = '0;
        step_valid = 1'b0;
        step_idx   = '0;
        step_axis  = 1'b0;
        step_sign  = 1'b0;
        frame_done = 1'b0;
        busy       = (state_q != StIdle);
        // A tick that lands mid-pass is dropped, only flagged one cycle later.
        overrun_d  = move_clk && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (move_clk) begin
                    mask_d  = obj_en;
                    idx_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (mask_q[idx_q]) begin
                    rd_en   = 1'b1;
                    rd_idx  = idx_q;
                    state_d = StLoad;
                end else begin
                    state_d = StNext;
                end
            end
            StLoad: begin
                sign_x_d = dir_in[5];
                x_cnt_d  = dir_in[4:3];
                sign_y_d = dir_in[2];
                y_cnt_d  = dir_in[1:0];
                if (dir_in[4:3] != 2'd0) begin
                    state_d = StStepX;
                end else if (dir_in[1:0] != 2'd0) begin
                    state_d = StStepY;
                end else begin
                    state_d = StNext;
                end
            end
            StStepX: begin
                step_valid = 1'b1;
                step_idx   = idx_q;
                step_axis  = 1'b0;
                step_sign  = sign_x_q;
                if (step_ready) begin
                    x_cnt_d = x_cnt_q - 2'd1;
                    if (x_cnt_q == 2'd1) begin
                        state_d = (y_cnt_q != 2'd0) ? StStepY : StNext;
                    end
                end
            end
            StStepY: begin
                step_valid = 1'b1;
                step_idx   = idx_q;
                step_axis  = 1'b1;
                step_sign  = sign_y_q;
                if (step_ready) begin
                    y_cnt_d = y_cnt_q - 2'd1;
                    if (y_cnt_q == 2'd1) begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StFetch;
                end
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_object_move_scheduler.sv
// Bench for object_move_scheduler: a queue model of reads/steps per pass, a per-cycle checker,
// and directed passes for the frame-timing, stall, overrun, mid-pass mask and reset cases.
module tb_object_move_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       move_clk = 1'b0;
    logic       step_ready = 1'b1;
    logic [7:0] obj_en = 8'h00;
    logic       rd_en;
    logic [2:0] rd_idx;
    logic [5:0] dir_in;
    logic       step_valid;
    logic [2:0] step_idx;
    logic       step_axis;
    logic       step_sign;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    object_move_scheduler #(.N_OBJ(8), .IDX_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_clk   (move_clk),
        .obj_en     (obj_en),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .dir_in     (dir_in),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_idx   (step_idx),
        .step_axis  (step_axis),
        .step_sign  (step_sign),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int frames = 0;
    int ovrs = 0;
    int rds = 0;
    int stalls = 0;
    logic [5:0] tab [8];
    int         exp_rd [$];
    logic [4:0] exp_step [$];
    logic [4:0] step_log [$];
    logic       prev_stall = 1'b0;
    logic [4:0] prev_s = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Direction table: data one cycle after the read strobe, junk otherwise.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) dir_in <= 6'h3F;
        else          dir_in <= rd_en ? tab[rd_idx] : 6'h3F;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [12:0] outs();
        return {rd_en, rd_idx, step_valid, step_idx, step_axis, step_sign, busy, frame_done,
                overrun};
    endfunction

    // Expected reads and steps of one pass; returns its inclusive length with ready held high.
    function automatic int build_model(input logic [7:0] m);
        int len = 2;
        exp_rd.delete();
        exp_step.delete();
        for (int i = 0; i < 8; i++) begin
            if (!m[i]) begin
                len += 2;
            end else begin
                int xm = int'(tab[i][4:3]);
                int ym = int'(tab[i][1:0]);
                exp_rd.push_back(i);
                for (int k = 0; k < xm; k++) exp_step.push_back({3'(i), 1'b0, tab[i][5]});
                for (int k = 0; k < ym; k++) exp_step.push_back({3'(i), 1'b1, tab[i][2]});
                len += 3 + xm + ym;
            end
        end
        return len;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            logic [4:0] s;
            s = {step_idx, step_axis, step_sign};
            if (rd_en) begin
                rds++;
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_idx", rd_idx, exp_rd.pop_front());
            end
            if (prev_stall) chk("step_hold", {step_valid, s}, {1'b1, prev_s});
            if (step_valid && step_ready) begin
                step_log.push_back(s);
                if (exp_step.size() == 0) chk("step_unexpected", 1, 0);
                else chk("step", s, exp_step.pop_front());
            end
            if (step_valid && !step_ready) stalls++;
            prev_stall = step_valid && !step_ready;
            prev_s = s;
            if (!busy) chk("idle_quiet", {rd_en, step_valid, frame_done}, 0);
            if (frame_done) frames++;
            if (overrun) ovrs++;
        end
    end

    task automatic run_pass(input string tag, input logic [7:0] m, input int stall,
                            input int ovr_at, input int chg_at, input logic [7:0] chg_m,
                            input int lit_len);
        int  mlen, nrd, t0, t1, n, held, f0, o0, r0, s0, ovc;
        bit  done;
        mlen = build_model(m) + stall;
        nrd  = exp_rd.size();
        step_log.delete();
        f0 = frames; o0 = ovrs; r0 = rds; s0 = stalls; ovc = -1; t1 = 0; held = 0;
        @(posedge clk); #1;
        obj_en = m;
        move_clk = 1'b1;
        step_ready = (stall == 0);
        t0 = cyc;
        n = 0;
        done = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            if (overrun) ovc = cyc - t0;
            if (step_valid && !step_ready) held++;
            if (frame_done) begin
                done = 1;
                t1 = cyc;
            end
            @(posedge clk); #1;
            n++;
            move_clk = (n == ovr_at);
            if (n == chg_at) obj_en = chg_m;
            if (held >= stall) step_ready = 1'b1;
        end
        move_clk = 1'b0;
        step_ready = 1'b1;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_len"}, t1 - t0 + 1, mlen);
        if (lit_len != 0) chk({tag, "_len_lit"}, t1 - t0 + 1, lit_len);
        repeat (2) @(negedge clk);
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        chk({tag, "_step_left"}, exp_step.size(), 0);
        chk({tag, "_rd_count"}, rds - r0, nrd);
        chk({tag, "_stall_cycles"}, stalls - s0, stall);
        chk({tag, "_frames"}, frames - f0, 1);
        chk({tag, "_overruns"}, ovrs - o0, (ovr_at != 0) ? 1 : 0);
        if (ovr_at != 0) chk({tag, "_overrun_cycle"}, ovc, ovr_at + 1);
        repeat (5) @(negedge clk);
        chk({tag, "_no_second_pass"}, {busy, 32'(frames - f0)}, {1'b0, 32'd1});
    endtask

    initial begin
        logic [4:0] lit35 [3];
        logic [4:0] got;
        int  f0, n;
        bit  found;
        lit35[0] = 5'b000_0_0;
        lit35[1] = 5'b000_0_0;
        lit35[2] = 5'b000_1_1;

        for (int i = 0; i < 8; i++) tab[i] = 6'b000000;
        #1 reset_n = 1'b0;
        #1 chk("reset_async_outputs", outs(), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_idle", outs(), 0);

        // Single slot, x twice positive then y once negative.
        tab[0] = 6'b0_10_1_01;
        run_pass("r35", 8'h01, 0, 0, 0, 8'h00, 22);
        for (int k = 0; k < 3; k++) begin
            got = (k < step_log.size()) ? step_log[k] : 5'h1F;
            chk("r35_step_lit", got, lit35[k]);
        end

        for (int i = 0; i < 8; i++) tab[i] = 6'b000000;
        run_pass("r36", 8'hFF, 0, 0, 0, 8'h00, 26);

        // Stall the first step of slot 2 for four cycles.
        tab[2] = 6'b1_11_0_00;
        run_pass("r37", 8'h04, 4, 0, 0, 8'h00, 26);
        chk("r37_accepts", step_log.size(), 3);
        for (int k = 0; k < 3; k++) begin
            got = (k < step_log.size()) ? step_log[k] : 5'h1F;
            chk("r37_step_lit", got, 5'b010_0_1);
        end

        for (int i = 0; i < 8; i++) tab[i] = {i[0], 2'b11, i[1], 2'b11};
        run_pass("r30", 8'hFF, 0, 0, 0, 8'h00, 74);

        tab[0] = 6'b0_10_1_01;
        run_pass("r38", 8'h01, 0, 2, 0, 8'h00, 22);

        for (int i = 0; i < 8; i++) tab[i] = 6'(i * 7 + 3);
        run_pass("r40a", 8'hFF, 0, 0, 5, 8'h00, 0);
        run_pass("r40b", 8'h00, 0, 0, 0, 8'h00, 18);

        // Reset while slot 5 is stepping y.
        void'(build_model(8'hFF));
        @(posedge clk); #1;
        obj_en = 8'hFF;
        move_clk = 1'b1;
        @(posedge clk); #1;
        move_clk = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < 500) begin
            @(negedge clk);
            if (step_valid && step_axis && step_idx == 3'd5) found = 1;
            n++;
        end
        chk("r39_reach_slot5_y", found, 1);
        #2 reset_n = 1'b0;
        #1 chk("r39_async_zero", outs(), 0);
        exp_rd.delete();
        exp_step.delete();
        f0 = frames;
        repeat (3) @(posedge clk);
        #1 chk("r39_held_zero", outs(), 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("r39_no_frame_done", frames - f0, 0);
        chk("r39_idle", busy, 0);
        run_pass("r39_restart", 8'hFF, 0, 0, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
